// File: rtl/bus_ram_pkg.sv
// Shared types and helpers for the 6502 bus RAM and its streaming loader.
package bus_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_e;

  localparam int unsigned OPEN_BUS_DFLT = 'hFF;

  // One extra bit on the window end so base+size near the top of the space cannot wrap.
  function automatic logic in_rom(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] size);
    logic [32:0] lim;
    lim = {1'b0, base} + {1'b0, size};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/bus_ram_if.sv
// CPU bus and loader stream bundled for the bus RAM; master is the CPU/loader side.
interface bus_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ab;
  logic [DATA_W-1:0] cpu_do;
  logic              we;
  logic [DATA_W-1:0] cpu_di;
  logic              rdy;
  logic              load_start;
  logic [ADDR_W-1:0] load_addr;
  logic [ADDR_W-1:0] load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic              load_busy;

  modport master (
    output ab, cpu_do, we, load_start, load_addr, load_len, load_valid, load_data,
    input  cpu_di, rdy, load_ready, load_done, load_busy
  );

  modport slave (
    input  ab, cpu_do, we, load_start, load_addr, load_len, load_valid, load_data,
    output cpu_di, rdy, load_ready, load_done, load_busy
  );
endinterface

// File: rtl/bus_ram_loader.sv
// Streaming loader FSM: walks ptr/cnt over the incoming words and holds the CPU off meanwhile.
module bus_ram_loader
  import bus_ram_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rdy,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_busy
);

  ld_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ptr, cnt;
  logic              zero_p1;
  logic              start_ok;

  assign start_ok = (state == IDLE) && load_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      zero_p1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      zero_p1 <= start_ok && (load_len == '0);
    end
  end

  // Pointer wraps at DEPTH so a load may run off the top of memory into address 0.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      ptr <= load_addr;
      cnt <= load_len;
    end else if (wr_en) begin
      ptr <= (ptr == ADDR_W'(DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
      cnt <= cnt - ADDR_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    case (state)
      IDLE: if (load_start && (load_len != '0)) state_nxt = LOAD;
      LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          if (cnt == ADDR_W'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_addr    = ptr;
  assign wr_data    = load_data;
  assign load_busy  = (state != IDLE);
  assign load_ready = load_busy;
  assign rdy        = ~load_busy;
  assign load_done  = (state == DONE) || zero_p1;

endmodule

// File: rtl/bus_ram.sv
// 6502 bus memory: address decode, write-protected ROM window, selectable read latency, loader port.
module bus_ram
  import bus_ram_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 65536,
  parameter int          READ_REG = 0,
  parameter int unsigned ROM_BASE = 'hE000,
  parameter int unsigned ROM_SIZE = 0,
  parameter int unsigned OPEN_BUS = OPEN_BUS_DFLT
) (
  input logic      clk,
  input logic      reset,
  bus_ram_if.slave bus
);

  localparam int               IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] OB   = DATA_W'(OPEN_BUS);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_rdy;
  logic [IDX_W-1:0]  ab_idx, ld_idx;
  logic              ab_ok, ld_ok, ab_prot;
  logic              cpu_wr, ld_wr;
  logic [DATA_W-1:0] rd_p0, rd_p1;

  function automatic logic implemented(input logic [ADDR_W-1:0] a);
    return 33'(a) < 33'(DEPTH);
  endfunction

  bus_ram_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .load_start (bus.load_start),
    .load_addr  (bus.load_addr),
    .load_len   (bus.load_len),
    .load_valid (bus.load_valid),
    .load_data  (bus.load_data),
    .wr_en      (ld_en),
    .wr_addr    (ld_addr),
    .wr_data    (ld_data),
    .rdy        (ld_rdy),
    .load_ready (bus.load_ready),
    .load_done  (bus.load_done),
    .load_busy  (bus.load_busy)
  );

  assign bus.rdy = ld_rdy;

  assign ab_idx  = bus.ab[IDX_W-1:0];
  assign ld_idx  = ld_addr[IDX_W-1:0];
  assign ab_ok   = implemented(bus.ab);
  assign ld_ok   = implemented(ld_addr);
  assign ab_prot = (ROM_SIZE != 0) && in_rom(32'(bus.ab), ROM_BASE, ROM_SIZE);

  // Loader ignores the ROM window so images can be written; the CPU is gated by rdy.
  assign ld_wr  = ld_en && ld_ok && !reset;
  assign cpu_wr = bus.we && ld_rdy && ab_ok && !ab_prot;

  always_ff @(posedge clk) begin
    if (ld_wr)       mem[ld_idx] <= ld_data;
    else if (cpu_wr) mem[ab_idx] <= bus.cpu_do;
  end

  // Stage p0: combinational lookup; p1: read-before-write registered copy.
  assign rd_p0 = ab_ok ? mem[ab_idx] : OB;

  always_ff @(posedge clk) begin
    if (reset) rd_p1 <= OB;
    else       rd_p1 <= rd_p0;
  end

  assign bus.cpu_di = (READ_REG != 0) ? rd_p1 : rd_p0;

endmodule

// File: doc/bus_ram.md
Name: bus_ram

Overview:
- Parametrised single-clock memory model/peripheral for the 6502 CPU bus. Replaces ad-hoc RAM arrays wired to the core's ab/di/do/we.
- Adds configurable width and depth, a selectable read mode, and a write-protected ROM window.
- Adds a streaming loader port that fills memory from a start address while holding the CPU off via rdy.
- Sits between the _6502 core and the system bus in the C64 top level and benches.

Parameters:
ADDR_W, 16, CPU address width in bits
DATA_W, 8, data width in bits
DEPTH, 65536, implemented words; must be <= 2**ADDR_W
READ_REG, 0, 0 = combinational read from ab; 1 = registered read, one-cycle latency
ROM_BASE, 'hE000, first address of the write-protected window
ROM_SIZE, 0, words in the protected window; 0 disables protection
OPEN_BUS, 'hFF, value read from unimplemented addresses

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
ab  in  ADDR_W  CPU address
cpu_do  in  DATA_W  write data from CPU
we  in  1  CPU write strobe, sampled on the clock edge
cpu_di  out  DATA_W  read data to CPU
rdy  out  1  high = CPU may proceed; low while the loader is active
load_start  in  1  one-cycle pulse that begins a load
load_addr  in  ADDR_W  load start address, sampled with load_start
load_len  in  ADDR_W  number of words to load, sampled with load_start; 0 means no load
load_valid  in  1  loader data valid
load_data  in  DATA_W  loader data
load_ready  out  1  block accepts load_data this cycle
load_done  out  1  one-cycle pulse when the last word is written
load_busy  out  1  high while in LOAD

Behaviour:
- Reset values: rdy=1, load_ready=0, load_done=0, load_busy=0, FSM=IDLE, cpu_di registered copy=OPEN_BUS.
- Reset does not clear memory contents.
- Address decode: address a is implemented when a < DEPTH. Otherwise reads return OPEN_BUS and writes are dropped.
- ROM window: ROM_BASE <= a < ROM_BASE+ROM_SIZE. CPU writes into the window are dropped. Loader writes into the window are performed, so ROM images can be loaded.
- READ_REG=0: cpu_di = mem[ab] combinationally. cpu_di is driven even when we=1; the write takes effect at the edge.
- READ_REG=1: cpu_di updates at the edge to the value of mem[ab] sampled at that edge (read-before-write), so the CPU sees it one cycle later.
- CPU write: on an edge with we=1, rdy=1, implemented address and not protected, mem[ab] <= cpu_do.
- CPU write when rdy=0: ignored.
- FSM IDLE:
  - load_start with load_len != 0 -> LOAD. Latch ptr=load_addr and cnt=load_len.
  - load_start with load_len = 0 -> stay IDLE and pulse load_done the next cycle.
- FSM LOAD:
  - rdy=0, load_busy=1, load_ready=1.
  - On each edge with load_valid=1: write load_data to mem[ptr] if implemented (the ROM window is not enforced), then ptr++, cnt--.
  - ptr wraps modulo DEPTH, e.g. DEPTH-1 -> 0.
  - When the accepted word is the last one (cnt=1) -> DONE.
- FSM DONE: load_done=1 for exactly one cycle; rdy, load_busy and load_ready stay as in LOAD. Next state IDLE.
- IDLE after a load: rdy=1 again in the first IDLE cycle.
- load_start while in LOAD or DONE: ignored.
- Simultaneous CPU we and loader write: cannot occur, because rdy=0 gates the CPU.
- Reset during LOAD: FSM goes to IDLE on that edge, no further loader writes, no load_done. Words already written stay in memory.
- Arithmetic: ptr and cnt are ADDR_W bits wide. The ROM window end is computed ADDR_W+1 bits wide so it cannot overflow.

Decomposition:
- Package bus_ram_pkg holds:
  - the FSM state enum (IDLE, LOAD, DONE);
  - a helper function in_rom(addr, base, size);
  - the OPEN_BUS default constant.
- One natural sub-module, bus_ram_loader: the FSM plus ptr/cnt. It outputs wr_en, wr_addr, wr_data and the status signals.
- The top level holds the memory array, the write mux (loader vs CPU), protection and decode.

Test Plan:
- Parameters: DEPTH=32, READ_REG=0, ROM_SIZE=0.
  - CPU writes 8'h14 to 20, then reads 20 -> cpu_di=8'h14 in the same cycle as ab=20.
  - Read ab=40 -> cpu_di=8'hFF.
  - Write to 40 -> no state change.
- Parameters: READ_REG=1.
  - Set ab=5 (mem[5]=8'h03) -> cpu_di=8'h03 one cycle later.
  - Write 8'hAA to 5 with ab held -> next-cycle read shows 8'h03, the cycle after shows 8'hAA.
- Parameters: ROM_BASE=16, ROM_SIZE=8, DEPTH=32.
  - CPU writes 8'h55 to 18 -> mem[18] unchanged.
  - Loader writes 8'h55 to 18 -> mem[18]=8'h55.
- Parameters: DEPTH=32.
  - load_start, load_addr=30, load_len=4, data A9,14,8D,00 with valid gaps.
  - Required: mem[30]=A9, mem[31]=14, mem[0]=8D, mem[1]=00.
  - rdy low throughout; load_done pulses once; rdy high the next cycle.
  - CPU we during the load has no effect.
- Reset during load:
  - Assert reset after 2 of 5 words -> load_busy=0 and rdy=1 after the edge, 2 words written, no load_done.
  - A new load_start is then accepted normally.
- load_len=0 -> load_done pulses once; rdy never drops; no memory change.
